// File: rtl/booth_arb_pkg.sv
// Shared types and constants for the Booth multiplier arbiter: tag layout,
// id-width helper and tag reset values.
package booth_arb_pkg;

   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Tag id field is sized for up to 256 requesters; the top uses the low bits.
   localparam int TAG_ID_W = 8;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   localparam logic                TAG_VALID_RST = 1'b0;
   localparam logic [TAG_ID_W-1:0] TAG_ID_RST    = '0;
   localparam tag_t                TAG_RST       = '{valid: TAG_VALID_RST, id: TAG_ID_RST};

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Requester arbiter: one-hot grant plus encoded id, round-robin by default,
// fixed priority (index 0 highest) when BOOTH_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
   import booth_arb_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int ID_W = id_width(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] i_req,
   output logic [NREQ-1:0] o_gnt,
   output logic [ID_W-1:0] o_gnt_id
);

   logic [NREQ-1:0] w_req;
   logic            w_found;

   // No grant is issued while reset is asserted.
   assign w_req = rst ? i_req : '0;

`ifdef BOOTH_ARB_FIXED_PRIO_EN

   always_comb begin
      o_gnt    = '0;
      o_gnt_id = '0;
      w_found  = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && w_req[k]) begin
            w_found  = 1'b1;
            o_gnt[k] = 1'b1;
            o_gnt_id = ID_W'(k);
         end
      end
   end

`else

   logic [ID_W-1:0] r_ptr;

   always_comb begin : p_pick
      int v_idx;
      o_gnt    = '0;
      o_gnt_id = '0;
      w_found  = 1'b0;
      v_idx    = 0;
      for (int k = 0; k < NREQ; k++) begin
         v_idx = int'(r_ptr) + k;
         if (v_idx >= NREQ) v_idx = v_idx - NREQ;
         if (!w_found && w_req[v_idx[ID_W-1:0]]) begin
            w_found                 = 1'b1;
            o_gnt[v_idx[ID_W-1:0]] = 1'b1;
            o_gnt_id                = v_idx[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ptr <= '0;
      end else if (w_found) begin
         r_ptr <= (int'(o_gnt_id) == NREQ-1) ? '0 : o_gnt_id + 1'b1;
      end
   end

`endif

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one fixed-latency multiplier among NREQ requesters and routes each
// product back by id; arbitration mode selected by BOOTH_ARB_FIXED_PRIO_EN.
module booth_mul_arbiter
   import booth_arb_pkg::*;
#(
   parameter  int N       = 16,
   parameter  int NREQ    = 4,
   parameter  int MUL_LAT = 2,
   localparam int ID_W    = id_width(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [N-1:0]      mul_a,
   output logic [N-1:0]      mul_b,
   input  logic [2*N-1:0]    mul_prod,
   output logic [NREQ-1:0]   rsp_valid,
   output logic [2*N-1:0]    rsp_prod,
   output logic [ID_W-1:0]   rsp_id,
   output logic              busy
);

   logic [NREQ-1:0] w_gnt;
   logic [ID_W-1:0] w_gnt_id;
   logic            w_any_gnt;
   tag_t            r_tag [MUL_LAT];
   tag_t            w_last;
   logic            w_rsp_vld;
   logic [ID_W-1:0] w_rsp_id;
   logic            w_tag_any;
   logic            w_unused_id;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_req    (req_valid),
      .o_gnt    (w_gnt),
      .o_gnt_id (w_gnt_id)
   );

   assign req_ready = w_gnt;
   assign w_any_gnt = |w_gnt;
   assign mul_a     = w_any_gnt ? req_a[w_gnt_id*N +: N] : '0;
   assign mul_b     = w_any_gnt ? req_b[w_gnt_id*N +: N] : '0;

   // Tag stage k mirrors the multiplier's stage k; no stalls, so it shifts every cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < MUL_LAT; i++) r_tag[i] <= TAG_RST;
      end else begin
         r_tag[0] <= '{valid: w_any_gnt, id: TAG_ID_W'(w_gnt_id)};
         for (int i = 1; i < MUL_LAT; i++) r_tag[i] <= r_tag[i-1];
      end
   end

   assign w_last      = r_tag[MUL_LAT-1];
   assign w_rsp_vld   = w_last.valid & rst;
   assign w_rsp_id    = w_last.id[ID_W-1:0];
   assign w_unused_id = ^w_last.id[TAG_ID_W-1:ID_W];

   always_comb begin
      rsp_valid = '0;
      rsp_id    = '0;
      rsp_prod  = '0;
      if (w_rsp_vld) begin
         rsp_valid[w_rsp_id] = 1'b1;
         rsp_id              = w_rsp_id;
         rsp_prod            = mul_prod;
      end
   end

   always_comb begin
      w_tag_any = 1'b0;
      for (int i = 0; i < MUL_LAT; i++) w_tag_any = w_tag_any | r_tag[i].valid;
   end

   assign busy = rst & (w_tag_any | (|req_valid));

endmodule
